// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF stage: PC register, IF/ID pipeline register, fetch fault detection
// Statistics counters are built only when FETCH_STAT_EN is defined; otherwise the ports read 0.
module pc_fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_d,
   input  logic [31:0] npc,
   input  logic        int_req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic        valid_d,
   output logic        bd_d,
   output logic [4:0]  exc_d,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
   localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;
   localparam logic [4:0]  EXC_NONE = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] instr_d_q, instr_d_d;
   logic [31:0] pc_d_q, pc_d_d;
   logic        valid_d_q, valid_d_d;
   logic        bd_d_q, bd_d_d;
   logic [4:0]  exc_d_q, exc_d_d;
   logic        fetch_fault;
   logic        load_en;

   always_comb begin
      fetch_fault = (pc_f_q[1:0] != 2'b00) || (pc_f_q < TEXT_LO) || (pc_f_q > TEXT_HI);
      load_en     = !int_req && !eret && !stall;
      pc_f_d      = pc_f_q;
      instr_d_d   = instr_d_q;
      pc_d_d      = pc_d_q;
      valid_d_d   = valid_d_q;
      bd_d_d      = bd_d_q;
      exc_d_d     = exc_d_q;
      if (int_req) begin
         pc_f_d    = EXC_VEC;
         instr_d_d = 32'd0;
         pc_d_d    = EXC_VEC;
         valid_d_d = 1'b0;
         bd_d_d    = 1'b0;
         exc_d_d   = EXC_NONE;
      end else if (eret) begin
         // eret has no delay slot, so D is flushed rather than loaded
         pc_f_d    = epc;
         instr_d_d = 32'd0;
         pc_d_d    = epc;
         valid_d_d = 1'b0;
         bd_d_d    = 1'b0;
         exc_d_d   = EXC_NONE;
      end else if (load_en) begin
         pc_f_d    = branch_d ? npc : pc_f_q + 32'd4;
         instr_d_d = fetch_fault ? 32'd0 : instr_f;
         pc_d_d    = pc_f_q;
         valid_d_d = 1'b1;
         bd_d_d    = branch_d;
         exc_d_d   = fetch_fault ? EXC_ADEL : EXC_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_q    <= RESET_PC;
         instr_d_q <= 32'd0;
         pc_d_q    <= RESET_PC;
         valid_d_q <= 1'b0;
         bd_d_q    <= 1'b0;
         exc_d_q   <= EXC_NONE;
      end else begin
         pc_f_q    <= pc_f_d;
         instr_d_q <= instr_d_d;
         pc_d_q    <= pc_d_d;
         valid_d_q <= valid_d_d;
         bd_d_q    <= bd_d_d;
         exc_d_q   <= exc_d_d;
      end
   end

   assign pc_f    = pc_f_q;
   assign instr_d = instr_d_q;
   assign pc_d    = pc_d_q;
   assign valid_d = valid_d_q;
   assign bd_d    = bd_d_q;
   assign exc_d   = exc_d_q;

`ifdef FETCH_STAT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        stall_hold;

   always_comb begin
      stall_hold  = stall && !int_req && !eret;
      fetch_cnt_d = fetch_cnt_q + {31'd0, load_en};
      stall_cnt_d = stall_cnt_q + {31'd0, stall_hold};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign fetch_cnt = 32'd0;
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a behavioural model
// Counter expectations follow FETCH_STAT_EN as defined for the build.
module tb_pc_fetch_unit;

`ifdef FETCH_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stall, branch_d, int_req, eret;
   logic [31:0] npc, epc, instr_f;
   logic [31:0] pc_f, instr_d, pc_d, fetch_cnt, stall_cnt;
   logic        valid_d, bd_d;
   logic [4:0]  exc_d;

   pc_fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_d(branch_d), .npc(npc),
      .int_req(int_req), .eret(eret), .epc(epc), .instr_f(instr_f),
      .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
      .bd_d(bd_d), .exc_d(exc_d), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // reference state: what the outputs must read after the most recent edge
   logic [31:0] m_pc, m_instr, m_pcd, m_fcnt, m_scnt;
   logic        m_valid, m_bd;
   logic [4:0]  m_exc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic flush_model(input logic [31:0] target);
      m_pc    = target;
      m_pcd   = target;
      m_instr = 32'd0;
      m_valid = 1'b0;
      m_bd    = 1'b0;
      m_exc   = 5'd0;
   endtask

   task automatic model_step();
      bit bad;
      if (reset) begin
         flush_model(32'h3000);
         m_fcnt = 0;
         m_scnt = 0;
      end else if (int_req) begin
         flush_model(32'h4180);
      end else if (eret) begin
         flush_model(epc);
      end else if (stall) begin
         if (STAT_EN) m_scnt = m_scnt + 1;
      end else begin
         bad     = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
         m_pcd   = m_pc;
         m_instr = bad ? 32'd0 : instr_f;
         m_exc   = bad ? 5'd4 : 5'd0;
         m_valid = 1'b1;
         m_bd    = branch_d;
         m_pc    = branch_d ? npc : m_pc + 32'd4;
         if (STAT_EN) m_fcnt = m_fcnt + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic rst, input logic st, input logic br, input logic [31:0] n,
                        input logic ir, input logic er, input logic [31:0] ep);
      reset = rst; stall = st; branch_d = br; npc = n; int_req = ir; eret = er; epc = ep;
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] r;
      r = 32'h3000 + ($urandom_range(0, 4095) << 2);
      case ($urandom_range(0, 9))
         0: return $urandom;
         1: return r | 32'd2;
         2: return 32'hFFFF_FFFC;
         3: return 32'h0000_6FFC;
         4: return 32'h0000_2FFC;
         default: return r;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_f", pc_f, m_pc);
         chk("instr_d", instr_d, m_instr);
         chk("pc_d", pc_d, m_pcd);
         chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
         chk("bd_d", {31'd0, bd_d}, {31'd0, m_bd});
         chk("exc_d", {27'd0, exc_d}, {27'd0, m_exc});
         chk("fetch_cnt", fetch_cnt, m_fcnt);
         chk("stall_cnt", stall_cnt, m_scnt);
      end
   end

   initial begin
      instr_f = 32'd0;
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      chk_en = 1'b1;
      chk("rst_pc_f", pc_f, 32'h3000);
      chk("rst_pc_d", pc_d, 32'h3000);
      chk("rst_valid", {31'd0, valid_d}, 32'd0);
      chk("rst_instr", instr_d, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);

      drive(0, 0, 0, 0, 0, 0, 0);
      instr_f = 32'h2409_0001;
      tick(); chk("seq_pc1", pc_f, 32'h3004);
      tick(); chk("seq_pc2", pc_f, 32'h3008);
      tick(); chk("seq_pc3", pc_f, 32'h300C);
      chk("seq_pc_d", pc_d, 32'h3008);
      chk("seq_valid", {31'd0, valid_d}, 32'd1);
      chk("seq_bd", {31'd0, bd_d}, 32'd0);
      chk("seq_instr", instr_d, 32'h2409_0001);
      chk("seq_fetch_cnt", fetch_cnt, STAT_EN ? 32'd3 : 32'd0);
      tick(); chk("seq_pc4", pc_f, 32'h3010);

      drive(0, 0, 1, 32'h3040, 0, 0, 0);
      tick();
      chk("br_pc_f", pc_f, 32'h3040);
      chk("br_pc_d", pc_d, 32'h3010);
      chk("br_bd", {31'd0, bd_d}, 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("br_next_pc_f", pc_f, 32'h3044);
      chk("br_next_bd", {31'd0, bd_d}, 32'd0);

      drive(0, 0, 1, 32'h3020, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0, 0);
      tick(); tick();
      chk("stall_pc_f", pc_f, 32'h3020);
      chk("stall_pc_d", pc_d, 32'h3044);
      chk("stall_cnt2", stall_cnt, STAT_EN ? 32'd2 : 32'd0);

      drive(0, 1, 1, 32'h3080, 1, 0, 0);
      tick();
      chk("int_pc_f", pc_f, 32'h4180);
      chk("int_valid", {31'd0, valid_d}, 32'd0);
      chk("int_instr", instr_d, 32'd0);
      chk("int_pc_d", pc_d, 32'h4180);
      drive(0, 0, 0, 0, 0, 1, 32'h3024);
      tick();
      chk("eret_pc_f", pc_f, 32'h3024);
      chk("eret_valid", {31'd0, valid_d}, 32'd0);

      drive(0, 0, 1, 32'h3002, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("adel_exc", {27'd0, exc_d}, 32'd4);
      chk("adel_instr", instr_d, 32'd0);
      chk("adel_pc_d", pc_d, 32'h3002);
      drive(0, 0, 1, 32'h7000, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("adel_hi_exc", {27'd0, exc_d}, 32'd4);
      chk("adel_hi_pc_d", pc_d, 32'h7000);

      drive(1, 0, 0, 0, 0, 1, 32'h3500);
      tick();
      chk("rst_eret_pc_f", pc_f, 32'h3000);
      chk("rst_eret_pc_d", pc_d, 32'h3000);
      chk("rst_eret_valid", {31'd0, valid_d}, 32'd0);
      chk("rst_eret_exc", {27'd0, exc_d}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 20, pick_addr(),
               $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4, pick_addr());
         instr_f = $urandom;
         tick();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset; ports SHALL be exactly as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hazard stall; hold PC and the IF/ID register.
REQ-005 branch_d  input  1  instruction in D is beq/j/jal/jr-class; take npc.
REQ-006 npc  input  32  next-PC target computed in D.
REQ-007 int_req  input  1  CP0 exception/interrupt entry request.
REQ-008 eret  input  1  eret in D; return to epc.
REQ-009 epc  input  32  CP0 EPC value.
REQ-010 instr_f  input  32  instruction-memory word at pc_f.
REQ-011 pc_f  output  32  current fetch address.
REQ-012 instr_d, pc_d  output  32 each  IF/ID instruction and its PC.
REQ-013 valid_d  output  1  IF/ID holds a real fetched instruction, not a bubble.
REQ-014 bd_d  output  1  instruction in D is a branch delay slot.
REQ-015 exc_d  output  5  fetch exception code: 0 none, 4 AdEL.
REQ-016 fetch_cnt, stall_cnt  output  32 each  statistics counters (see Configuration).

Function
REQ-017 Next-state priority SHALL be: reset > int_req > eret > stall > branch_d > sequential.
REQ-018 int_req SHALL load pc_f=0x0000_4180 and flush IF/ID: instr_d=0, valid_d=0, bd_d=0, exc_d=0, pc_d=0x4180. This SHALL override stall.
REQ-019 eret without int_req SHALL load pc_f=epc and flush IF/ID as in REQ-018, with pc_d=epc. No delay slot follows eret.
REQ-020 stall without int_req or eret SHALL hold pc_f and every IF/ID output unchanged.
REQ-021 Otherwise, branch_d=1 SHALL load pc_f=npc. The instruction at the old pc_f SHALL enter D with bd_d=1.
REQ-022 Otherwise pc_f SHALL become pc_f+4, modulo 2^32, and the fetched instruction SHALL enter D with bd_d=0.
REQ-023 An IF/ID load SHALL capture pc_d=pc_f and valid_d=1, with a latency of one cycle from fetch to D.
REQ-024 Fetch fault: if pc_f[1:0]!=0, or pc_f<0x3000, or pc_f>0x6FFC, the load SHALL capture exc_d=4 and instr_d=0; pc_d and bd_d SHALL load normally.
REQ-025 A faulting pc_f SHALL still advance per REQ-021 and REQ-022 until int_req arrives.
REQ-026 pc_f SHALL never be modified combinationally; all outputs SHALL be registered.

Reset
REQ-027 On reset: pc_f=0x0000_3000, instr_d=0, pc_d=0x0000_3000, valid_d=0, bd_d=0, exc_d=0, fetch_cnt=0, stall_cnt=0.
REQ-028 Reset asserted mid-stall, mid-eret, or together with int_req SHALL win on that edge. The first fetch after deassertion SHALL be from 0x3000.

Configuration
REQ-029 Macro FETCH_STAT_EN SHALL control the statistics counters.
REQ-030 With FETCH_STAT_EN defined:
- fetch_cnt SHALL increment, wrapping at 2^32, on each cycle with a valid IF/ID load.
- stall_cnt SHALL increment, wrapping at 2^32, on each cycle with stall=1 and no int_req/eret.
REQ-031 Without FETCH_STAT_EN: both ports SHALL remain present, tied to constant 0, with no counter flops.

Verification
REQ-032 Reset, then 3 free cycles, instr_f=0x2409_0001 -> pc_f goes 0x3000,0x3004,0x3008,0x300C; pc_d=0x3008, valid_d=1, bd_d=0.
REQ-033 pc_f=0x3010, branch_d=1, npc=0x3040 -> next pc_f=0x3040; pc_d=0x3010, bd_d=1; the following cycle pc_f=0x3044 and bd_d=0.
REQ-034 stall=1 for 2 cycles at pc_f=0x3020 -> pc_f and pc_d are frozen; stall_cnt +2 with macro, 0 without.
REQ-035 stall=1, branch_d=1 and int_req=1 together -> pc_f=0x4180, valid_d=0, instr_d=0; then eret=1 with epc=0x3024 -> pc_f=0x3024, valid_d=0.
REQ-036 jr to npc=0x3002 -> following load has exc_d=4, instr_d=0, pc_d=0x3002; npc=0x7000 likewise gives exc_d=4.
REQ-037 reset=1 together with eret=1 and epc=0x3500 -> pc_f=0x3000 and all IF/ID outputs at reset values.
